// File: rtl/module_spi_reg_arbiter.sv
// Two-requester round-robin sequencer for the SPI register bank: writes the data word,
// writes the control word with send set, polls for send=0, then returns the RX word.
module module_spi_reg_arbiter #(
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              req_a_i,
  input  logic [DATA_W-1:0] ctrl_a_i,
  input  logic [DATA_W-1:0] data_a_i,
  output logic              gnt_a_o,
  output logic              done_a_o,
  input  logic              req_b_i,
  input  logic [DATA_W-1:0] ctrl_b_i,
  input  logic [DATA_W-1:0] data_b_i,
  output logic              gnt_b_o,
  output logic              done_b_o,
  input  logic [DATA_W-1:0] ctrl_rd_i,
  input  logic [DATA_W-1:0] data_rd_i,
  output logic              wr_o,
  output logic              reg_sel_o,
  output logic [DATA_W-1:0] wr_data_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              err_o,
  output logic              busy_o,
  output logic [2:0]        dbg_state_o
);

  // Handshake: req_x_i is a level sampled only in IDLE; gnt_x_o pulses one cycle once the
  // requester's ctrl/data words are captured (req may drop from then on); done_x_o pulses
  // one cycle with rx_data_o and err_o valid. Req activity outside IDLE is ignored.

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WR_DATA   = 3'd1,
    ST_WR_CTRL   = 3'd2,
    ST_SETTLE    = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_RESP      = 3'd5
  } state_e;

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic TO_EN = (TIMEOUT_CYC != 0);
  localparam logic [DATA_W-1:0] SEND_BIT = DATA_W'(1);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;        // 0 = A, 1 = B
  logic              last_q, last_d;          // requester granted most recently
  logic [DATA_W-1:0] ctrl_lat_q, ctrl_lat_d;
  logic [DATA_W-1:0] data_lat_q, data_lat_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              to_hit;
  logic              pick;

  logic              wr_q, wr_d;
  logic              reg_sel_q, reg_sel_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              gnt_a_q, gnt_a_d;
  logic              gnt_b_q, gnt_b_d;
  logic              done_a_q, done_a_d;
  logic              done_b_q, done_b_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  logic              unused_ctrl_rd;
  assign unused_ctrl_rd = ^ctrl_rd_i[DATA_W-1:1];

  // Both requesting: serve the one not granted last; otherwise the sole requester.
  assign pick = (req_a_i && req_b_i) ? ~last_q : req_b_i;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    ctrl_lat_d = ctrl_lat_q;
    data_lat_d = data_lat_q;
    cnt_d      = cnt_q;
    to_hit     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_a_i || req_b_i) begin
          owner_d    = pick;
          last_d     = pick;
          ctrl_lat_d = pick ? ctrl_b_i : ctrl_a_i;
          data_lat_d = pick ? data_b_i : data_a_i;
          state_d    = ST_WR_DATA;
        end
      end
      ST_WR_DATA: state_d = ST_WR_CTRL;
      ST_WR_CTRL: state_d = ST_SETTLE;
      ST_SETTLE: begin
        cnt_d   = '0;
        state_d = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (!ctrl_rd_i[0]) begin
          state_d = ST_RESP;
        end else if (TO_EN && (cnt_q == CNT_LAST)) begin
          to_hit  = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every port comes straight from a flop.
  always_comb begin
    wr_d      = (state_d == ST_WR_DATA) || (state_d == ST_WR_CTRL);
    reg_sel_d = (state_d == ST_WR_DATA);
    wr_data_d = '0;
    if (state_d == ST_WR_DATA) begin
      wr_data_d = data_lat_d;
    end else if (state_d == ST_WR_CTRL) begin
      wr_data_d = ctrl_lat_q | SEND_BIT;
    end
    gnt_a_d   = (state_d == ST_WR_DATA) && !owner_d;
    gnt_b_d   = (state_d == ST_WR_DATA) &&  owner_d;
    done_a_d  = (state_d == ST_RESP) && !owner_d;
    done_b_d  = (state_d == ST_RESP) &&  owner_d;
    err_d     = (state_d == ST_RESP) && to_hit;
    busy_d    = (state_d != ST_IDLE);
    rx_data_d = (state_d == ST_RESP) ? data_rd_i : rx_data_q;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      ctrl_lat_q <= '0;
      data_lat_q <= '0;
      cnt_q      <= '0;
      wr_q       <= 1'b0;
      reg_sel_q  <= 1'b0;
      wr_data_q  <= '0;
      rx_data_q  <= '0;
      gnt_a_q    <= 1'b0;
      gnt_b_q    <= 1'b0;
      done_a_q   <= 1'b0;
      done_b_q   <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      ctrl_lat_q <= ctrl_lat_d;
      data_lat_q <= data_lat_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      reg_sel_q  <= reg_sel_d;
      wr_data_q  <= wr_data_d;
      rx_data_q  <= rx_data_d;
      gnt_a_q    <= gnt_a_d;
      gnt_b_q    <= gnt_b_d;
      done_a_q   <= done_a_d;
      done_b_q   <= done_b_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
    end
  end

  assign wr_o        = wr_q;
  assign reg_sel_o   = reg_sel_q;
  assign wr_data_o   = wr_data_q;
  assign rx_data_o   = rx_data_q;
  assign gnt_a_o     = gnt_a_q;
  assign gnt_b_o     = gnt_b_q;
  assign done_a_o    = done_a_q;
  assign done_b_o    = done_b_q;
  assign err_o       = err_q;
  assign busy_o      = busy_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_module_spi_reg_arbiter.sv
// Bench for module_spi_reg_arbiter: two instances (default timeout and a 16-cycle timeout)
// share stimulus; each transfer's timeline is predicted from the arbitration/timeout rules.
module tb_module_spi_reg_arbiter;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         req_a, req_b;
  logic [W-1:0] ctrl_a, data_a, ctrl_b, data_b, ctrl_rd, data_rd;

  logic         gnt_a0, gnt_b0, done_a0, done_b0, wr0, sel0, err0, busy0;
  logic [W-1:0] wdata0, rx0;
  logic [2:0]   unused_dbg0;
  logic         gnt_a1, gnt_b1, done_a1, done_b1, wr1, sel1, err1, busy1;
  logic [W-1:0] wdata1, rx1;
  logic [2:0]   unused_dbg1;
  logic [7:0]   flags0, flags1;

  assign flags0 = {wr0, sel0, gnt_a0, gnt_b0, done_a0, done_b0, err0, busy0};
  assign flags1 = {wr1, sel1, gnt_a1, gnt_b1, done_a1, done_b1, err1, busy1};

  module_spi_reg_arbiter #(.DATA_W(W)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_a_i(req_a), .ctrl_a_i(ctrl_a), .data_a_i(data_a), .gnt_a_o(gnt_a0), .done_a_o(done_a0),
    .req_b_i(req_b), .ctrl_b_i(ctrl_b), .data_b_i(data_b), .gnt_b_o(gnt_b0), .done_b_o(done_b0),
    .ctrl_rd_i(ctrl_rd), .data_rd_i(data_rd), .wr_o(wr0), .reg_sel_o(sel0),
    .wr_data_o(wdata0), .rx_data_o(rx0), .err_o(err0), .busy_o(busy0), .dbg_state_o(unused_dbg0)
  );

  module_spi_reg_arbiter #(.DATA_W(W), .TIMEOUT_CYC(16)) dut_to (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_a_i(req_a), .ctrl_a_i(ctrl_a), .data_a_i(data_a), .gnt_a_o(gnt_a1), .done_a_o(done_a1),
    .req_b_i(req_b), .ctrl_b_i(ctrl_b), .data_b_i(data_b), .gnt_b_o(gnt_b1), .done_b_o(done_b1),
    .ctrl_rd_i(ctrl_rd), .data_rd_i(data_rd), .wr_o(wr1), .reg_sel_o(sel1),
    .wr_data_o(wdata1), .rx_data_o(rx1), .err_o(err1), .busy_o(busy1), .dbg_state_o(unused_dbg1)
  );

  int           total = 0;
  int           bad = 0;
  logic [W-1:0] exp_rx [2];
  bit           last_b;
  int           tout [2];

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic int wait_cycles(input int blen, input int to);
    if (to != 0 && blen >= to) return to;
    return blen + 1;
  endfunction

  // Expected outputs c cycles after the grant edge, given n WAIT_DONE cycles.
  task automatic check(input int d, input int c, input int n, input bit e, input int win,
                       input logic [W-1:0] dw, input logic [W-1:0] cw, input logic [W-1:0] rxw);
    logic [7:0]   ef;
    logic [W-1:0] ew, er;
    ef = {(c == 1) || (c == 2), (c == 1), (c == 1) && (win == 0), (c == 1) && (win == 1),
          (c == 4 + n) && (win == 0), (c == 4 + n) && (win == 1), (c == 4 + n) && e, (c <= 4 + n)};
    ew = (c == 1) ? dw : (c == 2) ? (cw | {{(W-1){1'b0}}, 1'b1}) : '0;
    er = (c >= 4 + n) ? rxw : exp_rx[d];
    chk($sformatf("flags dut%0d c%0d", d, c), (d != 0) ? W'(flags1) : W'(flags0), W'(ef));
    chk($sformatf("wdata dut%0d c%0d", d, c), (d != 0) ? wdata1 : wdata0, ew);
    chk($sformatf("rx dut%0d c%0d", d, c), (d != 0) ? rx1 : rx0, er);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " flags dut0"}, W'(flags0), '0);
    chk({tag, " wdata dut0"}, wdata0, '0);
    chk({tag, " rx dut0"}, rx0, '0);
    chk({tag, " flags dut1"}, W'(flags1), '0);
    chk({tag, " wdata dut1"}, wdata1, '0);
    chk({tag, " rx dut1"}, rx1, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_a = 1'b0; req_b = 1'b0;
    #1 check_zero("reset");
    @(negedge clk);
    check_zero("reset held");
    rst_n = 1'b1;
    exp_rx[0] = '0; exp_rx[1] = '0;
    last_b = 1'b1;
  endtask

  // Called at a negedge while both instances are idle; runs one transfer end to end.
  // hold keeps the requests high so a follow-up grant happens straight after (blen < 16 only).
  task automatic run_xfer(input bit ra, input bit rb, input logic [W-1:0] ca, input logic [W-1:0] da,
                          input logic [W-1:0] cb, input logic [W-1:0] db, input int blen, input bit hold);
    int           win, nmin, nmax;
    int           n [2];
    bit           e [2];
    logic [W-1:0] cw, dw, rxw, tmp;
    bit           bz;
    req_a = ra; req_b = rb;
    ctrl_a = ca; data_a = da; ctrl_b = cb; data_b = db;
    win = (ra && rb) ? (last_b ? 0 : 1) : (rb ? 1 : 0);
    last_b = (win == 1);
    cw = (win == 1) ? cb : ca;
    dw = (win == 1) ? db : da;
    rxw = $urandom;
    data_rd = rxw;
    tmp = $urandom;
    ctrl_rd = {tmp[W-1:1], 1'b1};
    for (int d = 0; d < 2; d++) begin
      n[d] = wait_cycles(blen, tout[d]);
      e[d] = (tout[d] != 0) && (blen >= tout[d]);
    end
    nmin = (n[0] < n[1]) ? n[0] : n[1];
    nmax = (n[0] > n[1]) ? n[0] : n[1];
    for (int c = 1; c <= nmax + 5; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) check(d, c, n[d], e[d], win, dw, cw, rxw);
      bz = (c < 4) || (c - 4 < blen);
      tmp = $urandom;
      ctrl_rd = {tmp[W-1:1], bz};
      if (c == 4 + nmax) data_rd = $urandom;
      if (!hold) begin
        if (c >= 2 && c < 4 + nmin) begin
          tmp = $urandom;
          req_a = tmp[0]; req_b = tmp[1];
        end else begin
          req_a = 1'b0; req_b = 1'b0;
        end
      end
    end
    exp_rx[0] = rxw; exp_rx[1] = rxw;
  endtask

  initial begin
    logic [W-1:0] r0, r1, r2, r3, tmp;
    tout[0] = 1024; tout[1] = 16;
    rst_n = 1'b0;
    req_a = 1'b0; req_b = 1'b0;
    ctrl_a = '0; data_a = '0; ctrl_b = '0; data_b = '0; ctrl_rd = '0; data_rd = '0;
    exp_rx[0] = '0; exp_rx[1] = '0;
    last_b = 1'b1;
    do_reset();

    // Tie from reset: A first, then B while both keep requesting.
    run_xfer(1'b1, 1'b1, 32'h0000_0020, 32'h1111_2222, 32'h0000_0040, 32'h3333_4444, 2, 1'b1);
    run_xfer(1'b1, 1'b1, 32'h0000_0020, 32'h1111_2222, 32'h0000_0040, 32'h3333_4444, 1, 1'b0);

    // A only, minimum latency.
    do_reset();
    run_xfer(1'b1, 1'b0, 32'h0000_0010, 32'hA5A5_0001, 32'hDEAD_BEEF, 32'hCAFE_F00D, 0, 1'b0);

    // Fairness: both held high across four back-to-back transfers.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      r0 = $urandom; r1 = $urandom; r2 = $urandom; r3 = $urandom;
      run_xfer(1'b1, 1'b1, r0, r1, r2, r3, $urandom_range(0, 5), (i < 3));
    end

    // Random mix of requesters, words and busy lengths.
    for (int i = 0; i < 10; i++) begin
      r0 = $urandom; r1 = $urandom; r2 = $urandom; r3 = $urandom;
      tmp = W'($urandom_range(1, 3));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_xfer(tmp[0], tmp[1], r0, r1, r2, r3, $urandom_range(0, 12), tmp[2] ^ ($urandom_range(0, 1) == 1));
      req_a = 1'b0; req_b = 1'b0;
      @(negedge clk);
    end

    // Busy for 20 polls; then a stuck-busy run past both timeouts; then exactly at the limit.
    r0 = $urandom; r1 = $urandom;
    run_xfer(1'b0, 1'b1, r0, r1, 32'h0000_0102, 32'h0BAD_0BAD, 20, 1'b0);
    run_xfer(1'b1, 1'b0, 32'h0000_0300, 32'h7777_8888, r0, r1, 1100, 1'b0);
    run_xfer(1'b1, 1'b0, 32'h0000_0301, 32'h7777_8889, r0, r1, 15, 1'b0);
    run_xfer(1'b0, 1'b1, r0, r1, 32'h0000_0303, 32'h9999_AAAA, 16, 1'b0);

    // Reset while polling: outputs clear asynchronously, no done afterwards.
    req_a = 1'b1; req_b = 1'b0;
    ctrl_a = 32'h0000_0500; data_a = 32'h5555_6666;
    ctrl_rd = 32'h0000_0001;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      req_a = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1 check_zero("async rst");
    exp_rx[0] = '0; exp_rx[1] = '0;
    last_b = 1'b1;
    @(negedge clk);
    check_zero("rst held");
    rst_n = 1'b1;
    ctrl_rd = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check_zero($sformatf("post rst c%0d", c));
    end
    r0 = $urandom; r1 = $urandom;
    run_xfer(1'b1, 1'b0, 32'h0000_0600, 32'h1234_5678, r0, r1, 3, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
